// File: rtl/fetch_queue_pkg.sv
// rtl/fetch_queue_pkg.sv - shared CPU constants for the fetch queue and decoder
//
// Purpose: single home for the NOP encoding, the default fetch-queue depth and
//          the helper that sizes occupancy counters.
// Contents: CPU_NOP_INST, FQ_DEFAULT_DEPTH, count_width().
package fetch_queue_pkg;

  // addi x0, x0, 0
  localparam logic [31:0] CPU_NOP_INST     = 32'h0000_0013;
  localparam int          FQ_DEFAULT_DEPTH = 4;

  // An occupancy counter must hold 0..depth inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fq_ram.sv
// rtl/fq_ram.sv - fetch queue storage, one synchronous write port, one asynchronous read port
//
// Purpose: DEPTH x 64-bit entry array holding {pc, inst}; contents are not reset.
// Ports:
//   clk    - write clock
//   we     - write enable
//   waddr  - write address
//   wdata  - write data {pc, inst}
//   raddr  - read address
//   rdata  - read data, combinational from raddr
module fq_ram #(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [63:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [63:0]   rdata
);

  logic [63:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch queue between fetch and decode
//
// Purpose: FIFO of {pc, inst} pairs with flush, no bypass, NOP presented when empty.
// Optional: define FETCH_QUEUE_STATS_EN to add the flush_drops statistics output.
// Ports:
//   clk         - clock, rising edge
//   rst         - asynchronous active-low reset
//   in_valid    - fetch offers {in_pc, in_inst}
//   in_ready    - queue not full
//   in_pc       - offered PC
//   in_inst     - offered instruction
//   flush       - discard all entries, drop same-cycle transfers
//   out_valid   - head entry valid
//   out_ready   - decode consumes the head
//   out_pc      - head PC (0 when empty)
//   out_inst    - head instruction (NOP_INST when empty)
//   count       - number of valid entries
//   flush_drops - saturating sum of entries discarded by flush (stats build only)
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int          DEPTH    = FQ_DEFAULT_DEPTH,
  parameter logic [31:0] NOP_INST = CPU_NOP_INST,
  localparam int         AW       = $clog2(DEPTH),
  localparam int         CW       = count_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_pc,
  input  logic [31:0]   in_inst,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_pc,
  output logic [31:0]   out_inst,
  output logic [CW-1:0] count
`ifdef FETCH_QUEUE_STATS_EN
  ,
  output logic [15:0]   flush_drops
`endif
);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [63:0]   head;
  logic          enq;
  logic          deq;

  // Ready/valid come only from the registered count, so neither handshake
  // side sees a combinational path from the other.
  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);

  assign enq = in_valid && in_ready && !flush;
  assign deq = out_valid && out_ready && !flush;

  fq_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (enq),
    .waddr (wr_ptr),
    .wdata ({in_pc, in_inst}),
    .raddr (rd_ptr),
    .rdata (head)
  );

  // Stale array contents must never leak out while empty.
  assign out_pc   = out_valid ? head[63:32] : 32'h0;
  assign out_inst = out_valid ? head[31:0]  : NOP_INST;

  // DEPTH is a power of two, so pointer wrap is the natural AW-bit overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (deq) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({enq, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef FETCH_QUEUE_STATS_EN
  logic [16:0] drops_sum;

  assign drops_sum = {1'b0, flush_drops} + 17'(count);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flush_drops <= '0;
    end else if (flush) begin
      flush_drops <= drops_sum[16] ? 16'hFFFF : drops_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed self-checking bench for fetch_queue
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = '0;
  logic [31:0] in_inst = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [2:0]  count;
`ifdef FETCH_QUEUE_STATS_EN
  logic [15:0] flush_drops;
`endif

  int checks = 0;
  int failures = 0;
  int exp_drops = 0;

  fetch_queue dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_pc       (in_pc),
    .in_inst     (in_inst),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_inst    (out_inst),
    .count       (count)
`ifdef FETCH_QUEUE_STATS_EN
    ,
    .flush_drops (flush_drops)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_drops();
`ifdef FETCH_QUEUE_STATS_EN
    check("flush_drops", 32'(flush_drops), 32'(exp_drops));
`endif
  endtask

  task automatic offer(input logic [31:0] pc, input logic [31:0] inst);
    in_valid = 1'b1;
    in_pc    = pc;
    in_inst  = inst;
  endtask

  initial begin
    // Reset state, checked before any clock edge
    #2;
    check("rst_count", 32'(count), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_inst", out_inst, 32'h0000_0013);
    check("rst_out_pc", out_pc, 32'h0);
    check_drops();

    // First enqueue on the first edge after reset release, visible next cycle
    rst       = 1'b1;
    out_ready = 1'b0;
    offer(32'h0, 32'h0050_0093);
    step();
    in_valid = 1'b0;
    check("first_out_valid", 32'(out_valid), 32'd1);
    check("first_out_pc", out_pc, 32'h0);
    check("first_out_inst", out_inst, 32'h0050_0093);
    check("first_count", 32'(count), 32'd1);

    flush = 1'b1;
    step();
    flush = 1'b0;
    exp_drops = 1;
    check("flush1_count", 32'(count), 32'd0);
    check_drops();

    // Fill to DEPTH, fifth offer ignored, drain in order
    for (int i = 0; i < 4; i++) begin
      offer(32'(4 * i), 32'h100 + 32'(i));
      step();
    end
    check("full_count", 32'(count), 32'd4);
    check("full_in_ready", 32'(in_ready), 32'd0);
    offer(32'h10, 32'h1FF);
    step();
    check("fifth_ignored_count", 32'(count), 32'd4);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain_pc%0d", i), out_pc, 32'(4 * i));
      check($sformatf("drain_inst%0d", i), out_inst, 32'h100 + 32'(i));
      step();
    end
    check("drained_count", 32'(count), 32'd0);
    check("drained_out_valid", 32'(out_valid), 32'd0);
    check("drained_nop", out_inst, 32'h0000_0013);

    // Streaming: one-cycle latency, count stays 1, pointers wrap
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      offer(32'(4 * i), 32'h2000 + 32'(i));
      step();
      check($sformatf("stream_count%0d", i), 32'(count), 32'd1);
      check($sformatf("stream_pc%0d", i), out_pc, 32'(4 * i));
      check($sformatf("stream_inst%0d", i), out_inst, 32'h2000 + 32'(i));
    end
    in_valid = 1'b0;
    step();
    check("stream_end_count", 32'(count), 32'd0);

    // Full with same-cycle dequeue: new entry admitted only next cycle
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      offer(32'h40 + 32'(4 * i), 32'h300 + 32'(i));
      step();
    end
    offer(32'h50, 32'h304);
    out_ready = 1'b1;
    step();
    check("full_deq_count", 32'(count), 32'd3);
    check("full_deq_head", out_pc, 32'h44);
    out_ready = 1'b0;
    step();
    check("full_deq_refill", 32'(count), 32'd4);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("refill_pc%0d", i), out_pc, 32'h44 + 32'(4 * i));
      check($sformatf("refill_inst%0d", i), out_inst, 32'h301 + 32'(i));
      step();
    end
    check("refill_empty", 32'(count), 32'd0);

    // Flush with three queued and a same-cycle offer and consume
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      offer(32'h60 + 32'(4 * i), 32'h400 + 32'(i));
      step();
    end
    offer(32'h99, 32'h499);
    out_ready = 1'b1;
    flush     = 1'b1;
    step();
    flush     = 1'b0;
    in_valid  = 1'b0;
    exp_drops = exp_drops + 3;
    check("flush3_count", 32'(count), 32'd0);
    check("flush3_out_valid", 32'(out_valid), 32'd0);
    check("flush3_nop", out_inst, 32'h0000_0013);
    check("flush3_pc", out_pc, 32'h0);
    check_drops();
    step();
    check("flush3_dropped", 32'(count), 32'd0);
    out_ready = 1'b0;
    offer(32'h70, 32'h500);
    step();
    in_valid = 1'b0;
    check("post_flush_pc", out_pc, 32'h70);
    check("post_flush_inst", out_inst, 32'h500);

    // Asynchronous reset between edges with two entries queued
    offer(32'h74, 32'h501);
    step();
    in_valid = 1'b0;
    check("pre_rst_count", 32'(count), 32'd2);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_count", 32'(count), 32'd0);
    check("async_rst_out_valid", 32'(out_valid), 32'd0);
    check("async_rst_in_ready", 32'(in_ready), 32'd1);
    check("async_rst_nop", out_inst, 32'h0000_0013);
    exp_drops = 0;
    check_drops();
    #1;
    rst = 1'b1;
    offer(32'h80, 32'h600);
    step();
    in_valid = 1'b0;
    check("after_rst_count", 32'(count), 32'd1);
    check("after_rst_pc", out_pc, 32'h80);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
